// File: rtl/signed_div_seq_ctrl.sv
// Signed/unsigned division sequencer wrapped around an external unsigned divider array.
// Optional feature: define DIV_FASTPATH_EN to skip the divider when |op_a| < |op_b|.
module signed_div_seq_ctrl #(
   parameter int WIDTH       = 32,
   parameter int DIV_LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             is_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow,
   output logic [WIDTH-1:0] div_dividend,
   output logic [WIDTH-1:0] div_divisor,
   input  logic [WIDTH-1:0] div_quotient,
   input  logic [WIDTH-1:0] div_remainder
);

   localparam int CW = (DIV_LATENCY < 2) ? 1 : $clog2(DIV_LATENCY + 1);
   localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   typedef enum logic [1:0] {IDLE, WAIT, FIX, DONE} state_t;

   state_t           state_reg, state_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic             sign_a_reg, sign_a_next;
   logic             sign_b_reg, sign_b_next;
   logic [WIDTH-1:0] dividend_reg, dividend_next;
   logic [WIDTH-1:0] divisor_reg, divisor_next;
   logic [WIDTH-1:0] quotient_reg, quotient_next;
   logic [WIDTH-1:0] remainder_reg, remainder_next;
   logic             dbz_reg, dbz_next;
   logic             ovf_reg, ovf_next;

   logic             sign_a_in, sign_b_in;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic             accept, is_zero, is_ovf, is_fast;

   assign sign_a_in = is_signed & op_a[WIDTH-1];
   assign sign_b_in = is_signed & op_b[WIDTH-1];
   // MIN negates to itself, which is exactly its unsigned magnitude
   assign mag_a     = sign_a_in ? (~op_a + 1'b1) : op_a;
   assign mag_b     = sign_b_in ? (~op_b + 1'b1) : op_b;
   assign accept    = in_valid & (state_reg == IDLE);
   assign is_zero   = (op_b == '0);
   assign is_ovf    = is_signed & (op_a == MIN_VAL) & (op_b == ALL_ONES);

`ifdef DIV_FASTPATH_EN
   assign is_fast   = (mag_a < mag_b);
`else
   assign is_fast   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         sign_a_reg    <= 1'b0;
         sign_b_reg    <= 1'b0;
         dividend_reg  <= '0;
         divisor_reg   <= '0;
         quotient_reg  <= '0;
         remainder_reg <= '0;
         dbz_reg       <= 1'b0;
         ovf_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         sign_a_reg    <= sign_a_next;
         sign_b_reg    <= sign_b_next;
         dividend_reg  <= dividend_next;
         divisor_reg   <= divisor_next;
         quotient_reg  <= quotient_next;
         remainder_reg <= remainder_next;
         dbz_reg       <= dbz_next;
         ovf_reg       <= ovf_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      sign_a_next    = sign_a_reg;
      sign_b_next    = sign_b_reg;
      dividend_next  = dividend_reg;
      divisor_next   = divisor_reg;
      quotient_next  = quotient_reg;
      remainder_next = remainder_reg;
      dbz_next       = dbz_reg;
      ovf_next       = ovf_reg;
      unique case (state_reg)
         IDLE: begin
            if (accept) begin
               sign_a_next = sign_a_in;
               sign_b_next = sign_b_in;
               dbz_next    = 1'b0;
               ovf_next    = 1'b0;
               if (is_zero) begin
                  quotient_next  = ALL_ONES;
                  remainder_next = op_a;
                  dbz_next       = 1'b1;
                  state_next     = DONE;
               end else if (is_ovf) begin
                  quotient_next  = MIN_VAL;
                  remainder_next = '0;
                  ovf_next       = 1'b1;
                  state_next     = DONE;
               end else if (is_fast) begin
                  quotient_next  = '0;
                  remainder_next = op_a;
                  state_next     = DONE;
               end else begin
                  dividend_next = mag_a;
                  divisor_next  = mag_b;
                  cnt_next      = CW'(DIV_LATENCY);
                  state_next    = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_next = cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) begin
               state_next = FIX;
            end
         end
         FIX: begin
            // Truncating division: remainder follows the dividend's sign
            quotient_next  = (sign_a_reg ^ sign_b_reg) ? (~div_quotient + 1'b1) : div_quotient;
            remainder_next = sign_a_reg ? (~div_remainder + 1'b1) : div_remainder;
            dbz_next       = 1'b0;
            ovf_next       = 1'b0;
            state_next     = DONE;
         end
         DONE: begin
            if (out_ready) begin
               dbz_next   = 1'b0;
               ovf_next   = 1'b0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign in_ready     = (state_reg == IDLE);
   assign out_valid    = (state_reg == DONE);
   assign quotient     = quotient_reg;
   assign remainder    = remainder_reg;
   assign div_by_zero  = dbz_reg;
   assign overflow     = ovf_reg;
   assign div_dividend = dividend_reg;
   assign div_divisor  = divisor_reg;

endmodule

// File: tb/tb_signed_div_seq_ctrl.sv
// Directed and randomized checks of signed_div_seq_ctrl against a plain-arithmetic reference,
// with a pipelined unsigned divider model standing in for the divider array.
module tb_signed_div_seq_ctrl;

   localparam int W = 32;
   localparam int L = 1;
   localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0] ONES = '1;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         is_signed = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] quotient, remainder;
   logic         div_by_zero, overflow;
   logic [W-1:0] div_dividend, div_divisor;
   logic [W-1:0] div_quotient, div_remainder;

   int vectors = 0;
   int miscompares = 0;
   logic [W-1:0] last_dd = '0;
   logic [W-1:0] last_ds = '0;

   always #5 clk = ~clk;

   signed_div_seq_ctrl #(.WIDTH(W), .DIV_LATENCY(L)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .is_signed(is_signed),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero), .overflow(overflow),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_quotient(div_quotient), .div_remainder(div_remainder)
   );

   // Unsigned divider with L registered stages
   logic [W-1:0] pq [L];
   logic [W-1:0] pr [L];
   always @(posedge clk) begin
      pq[0] <= (div_divisor == '0) ? ONES : div_dividend / div_divisor;
      pr[0] <= (div_divisor == '0) ? div_dividend : div_dividend % div_divisor;
      for (int i = 1; i < L; i++) begin
         pq[i] <= pq[i-1];
         pr[i] <= pr[i-1];
      end
   end
   assign div_quotient  = pq[L-1];
   assign div_remainder = pr[L-1];

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                   output logic [W-1:0] q, output logic [W-1:0] r,
                                   output logic dz, output logic ov, output int lat);
      longint sa, sb, tq, tr;
      dz = 1'b0; ov = 1'b0; lat = L + 2;
      if (b == '0) begin
         q = ONES; r = a; dz = 1'b1; lat = 1;
      end else if (s && a == MINV && b == ONES) begin
         q = MINV; r = '0; ov = 1'b1; lat = 1;
      end else if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         tq = sa / sb;
         tr = sa % sb;
         q = tq[W-1:0];
         r = tr[W-1:0];
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int hold);
      logic [W-1:0] eq, er, emd, ems;
      logic edz, eov;
      int elat, lat, n;
      bit normal;
      ref_div(a, b, s, eq, er, edz, eov, elat);
      normal = !(edz || eov);
      emd = (s && a[W-1]) ? -a : a;
      ems = (s && b[W-1]) ? -b : b;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("in_ready_idle", W'(in_ready), W'(1));
      op_a = a; op_b = b; is_signed = s; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; op_a = $urandom; op_b = $urandom; is_signed = $urandom_range(0, 1);
      lat = 1;
      while (!out_valid && lat < 50) begin
         check("in_ready_busy", W'(in_ready), W'(0));
         check("div_dividend_stable", div_dividend, emd);
         check("div_divisor_stable", div_divisor, ems);
         @(posedge clk); #1; lat++;
      end
      check("latency", W'(lat), W'(elat));
      if (normal) begin
         last_dd = emd; last_ds = ems;
      end
      check("div_dividend_hold", div_dividend, last_dd);
      check("div_divisor_hold", div_divisor, last_ds);
      check("quotient", quotient, eq);
      check("remainder", remainder, er);
      check("div_by_zero", W'(div_by_zero), W'(edz));
      check("overflow", W'(overflow), W'(eov));
      $display("op a=%h b=%h s=%0d -> q=%h r=%h dz=%0d ov=%0d lat=%0d", a, b, s,
               quotient, remainder, div_by_zero, overflow, lat);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; op_a = 32'd5; op_b = 32'd1;
         @(posedge clk); #1;
         check("bp_out_valid", W'(out_valid), W'(1));
         check("bp_in_ready", W'(in_ready), W'(0));
         check("bp_quotient", quotient, eq);
         check("bp_remainder", remainder, er);
         check("bp_flags", W'({div_by_zero, overflow}), W'({edz, eov}));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      check("post_out_valid", W'(out_valid), W'(0));
      check("post_in_ready", W'(in_ready), W'(1));
      check("post_flags", W'({div_by_zero, overflow}), W'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [W-1:0] ra, rb;
      logic rs;
      int sel, nv;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", W'(in_ready), W'(1));
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_quotient", quotient, '0);
      check("rst_remainder", remainder, '0);
      check("rst_flags", W'({div_by_zero, overflow}), W'(0));
      check("rst_div_dividend", div_dividend, '0);
      check("rst_div_divisor", div_divisor, '0);
      rst = 1'b1;
      @(posedge clk); #1;

      run_op(32'd100, 32'd7, 1'b0, 0);
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
      run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
      run_op(32'h1234, 32'd0, 1'b0, 0);
      run_op(32'h1234, 32'd0, 1'b1, 1);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
      run_op(32'h8000_0000, 32'd3, 1'b1, 0);
      run_op(32'd3, 32'hFFFF_FFF0, 1'b1, 0);
      run_op(32'hDEAD_BEEF, 32'h1234, 1'b0, 5);
      run_op(32'd50, 32'd5, 1'b0, 0);

      // Reset while the divider is being waited on
      op_a = 32'd1000; op_b = 32'd3; is_signed = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      check("mid_rst_out_valid", W'(out_valid), W'(0));
      check("mid_rst_in_ready", W'(in_ready), W'(1));
      check("mid_rst_quotient", quotient, '0);
      check("mid_rst_remainder", remainder, '0);
      check("mid_rst_div_dividend", div_dividend, '0);
      last_dd = '0; last_ds = '0;
      nv = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid) nv++;
      end
      check("mid_rst_no_stale", W'(nv), W'(0));

      for (int k = 0; k < 40; k++) begin
         sel = $urandom_range(0, 9);
         ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
         case (sel)
            0: rb = '0;
            1: begin ra = MINV; rb = ONES; end
            2: rb = W'($urandom_range(1, 20));
            3: begin ra = W'($urandom_range(0, 50)); rb = W'($urandom_range(100, 1000)); end
            default: ;
         endcase
         run_op(ra, rb, rs, $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
